// File: rtl/tmds_deser_1to10.sv
// 1:10 TMDS word deserializer with control-token word alignment, driven by the 5x pixel clock.
// Optional `define TMDS_DESER_POLINV_EN inverts both serial inputs for swapped P/N routing.
module tmds_deser_1to10 #(
  parameter int SEARCH_WORDS  = 64,
  parameter int TOKEN_RUN     = 8,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic       clkx5,
  input  logic       rst,
  input  logic       din_h,
  input  logic       din_l,
  input  logic       resync,
  output logic [9:0] dataout,
  output logic       data_valid,
  output logic       token_det,
  output logic [1:0] ctl,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int MISS_W = $clog2(SEARCH_WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_WORDS + 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [1:0]        pair;
  logic [19:0]       hist_q;
  logic [2:0]        phase_q;
  logic [0:0]        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [3:0]        off_q, off_d;
  logic [9:0]        dout_q;
  logic              vld_q, tok_q;
  logic [1:0]        ctl_q;
  logic              sample;
  logic [9:0]        word;
  logic [2:0]        tok_dec;

`ifdef TMDS_DESER_POLINV_EN
  assign pair = ~{din_l, din_h};
`else
  assign pair = {din_l, din_h};
`endif

  // {detected, C1, C0}
  function automatic logic [2:0] decode_token(input logic [9:0] w);
    case (w)
      10'h354: decode_token = 3'b100;
      10'h0AB: decode_token = 3'b101;
      10'h154: decode_token = 3'b110;
      10'h2AB: decode_token = 3'b111;
      default: decode_token = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] slip(input logic [3:0] off);
    slip = (off == 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

  assign sample  = (phase_q == 3'd4);
  assign word    = 10'(hist_q >> off_q);
  assign tok_dec = decode_token(word);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    idle_d  = idle_q;
    off_d   = off_q;
    if (resync) begin
      // Overrides any lock/timeout decision on the same cycle, so only one slip happens.
      state_d = ST_SEARCH;
      off_d   = slip(off_q);
      run_d   = '0;
      miss_d  = '0;
      idle_d  = '0;
    end else if (sample) begin
      case (state_q)
        ST_SEARCH: begin
          if (tok_dec[2]) begin
            miss_d = '0;
            if (run_q >= RUN_W'(TOKEN_RUN - 1)) begin
              run_d   = RUN_W'(TOKEN_RUN);
              state_d = ST_LOCKED;
              idle_d  = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
            if (miss_q >= MISS_W'(SEARCH_WORDS - 1)) begin
              miss_d = '0;
              off_d  = slip(off_q);
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: begin
          if (tok_dec[2]) begin
            idle_d = '0;
          end else if (idle_q >= IDLE_W'(TIMEOUT_WORDS - 1)) begin
            state_d = ST_SEARCH;
            off_d   = slip(off_q);
            run_d   = '0;
            miss_d  = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clkx5 or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      phase_q <= '0;
      state_q <= ST_SEARCH;
      run_q   <= '0;
      miss_q  <= '0;
      idle_q  <= '0;
      off_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      tok_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      hist_q  <= {pair, hist_q[19:2]};
      phase_q <= sample ? 3'd0 : phase_q + 3'd1;
      state_q <= state_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      idle_q  <= idle_d;
      off_q   <= off_d;
      vld_q   <= sample;
      if (sample) begin
        dout_q <= word;
        tok_q  <= tok_dec[2];
        ctl_q  <= tok_dec[1:0];
      end
    end
  end

  assign dataout    = dout_q;
  assign data_valid = vld_q;
  assign token_det  = tok_q;
  assign ctl        = ctl_q;
  assign locked     = (state_q == ST_LOCKED);
  assign bit_offset = off_q;

endmodule

// File: tb/tb_tmds_deser_1to10.sv
// Scoreboard bench for tmds_deser_1to10: a word-level reference model predicts every output word.
module tb_tmds_deser_1to10;
  localparam int SW = 64;
  localparam int TR = 8;
  localparam int TW = 4096;

`ifdef TMDS_DESER_POLINV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clkx5 = 1'b0;
  logic       rst, din_h, din_l, resync;
  logic [9:0] dataout;
  logic       data_valid, token_det, locked;
  logic [1:0] ctl;
  logic [3:0] bit_offset;

  tmds_deser_1to10 #(.SEARCH_WORDS(SW), .TOKEN_RUN(TR), .TIMEOUT_WORDS(TW)) dut (
    .clkx5(clkx5), .rst(rst), .din_h(din_h), .din_l(din_l), .resync(resync),
    .dataout(dataout), .data_valid(data_valid), .token_det(token_det), .ctl(ctl),
    .locked(locked), .bit_offset(bit_offset)
  );

  always #5 clkx5 = ~clkx5;

  typedef struct packed {
    logic [9:0] w;
    logic       det;
    logic [1:0] c;
    logic       lk;
    logic [3:0] off;
  } exp_t;

  exp_t sb[$];
  bit   sent[$];
  int   n;
  logic [9:0] cur_word;
  int   dly;
  int   m_state, m_run, m_miss, m_idle, m_off;
  bit   rs_on_lock;
  int   n_chk, n_fail;
  int   tok_cnt, nontok_run, lock_tok, drop_run, drop_off, off_moves, prev_off;
  logic prev_lk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] tok(input logic [9:0] w);
    if (w == 10'h354) return 3'b100;
    if (w == 10'h0AB) return 3'b101;
    if (w == 10'h154) return 3'b110;
    if (w == 10'h2AB) return 3'b111;
    return 3'b000;
  endfunction

  // Serial index 2n is din_h on edge n after reset release; bit 0 of a word falls on multiples of 10.
  function automatic logic sbit(input int k);
    if (k < dly) return 1'b0;
    return cur_word[(k - dly) % 10];
  endfunction

  function automatic logic [9:0] window(input int nn, input int off);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) begin
      int idx;
      idx = 2 * (nn - 10) + off + j;
      r[j] = (idx >= 0 && idx < sent.size()) ? sent[idx] : 1'b0;
    end
    return r;
  endfunction

  function automatic int nslip(input int off);
    return (off == 9) ? 0 : off + 1;
  endfunction

  task automatic tick();
    logic b0, b1;
    logic [9:0] w;
    logic [2:0] t;
    bit samp;
    exp_t e;
    n++;
    b0 = sbit(2 * n);
    b1 = sbit(2 * n + 1);
    sent.push_back(b0);
    sent.push_back(b1);
    din_h = b0 ^ INV;
    din_l = b1 ^ INV;
    samp = (n % 5 == 0);
    w = window(n, m_off);
    t = tok(w);
    resync = 1'b0;
    if (rs_on_lock && samp && m_state == 0 && t[2] && m_run == TR - 1) begin
      resync = 1'b1;
      rs_on_lock = 1'b0;
    end
    @(posedge clkx5);
    if (resync) begin
      m_state = 0; m_off = nslip(m_off); m_run = 0; m_miss = 0; m_idle = 0;
    end else if (samp) begin
      if (m_state == 0) begin
        if (t[2]) begin
          m_miss = 0;
          m_run++;
          if (m_run >= TR) begin m_run = TR; m_state = 1; m_idle = 0; end
        end else begin
          m_run = 0;
          m_miss++;
          if (m_miss >= SW) begin m_miss = 0; m_off = nslip(m_off); end
        end
      end else begin
        if (t[2]) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle >= TW) begin
            m_state = 0; m_off = nslip(m_off); m_run = 0; m_miss = 0; m_idle = 0;
          end
        end
      end
    end
    if (samp) begin
      e.w = w; e.det = t[2]; e.c = t[1:0]; e.lk = (m_state == 1); e.off = 4'(m_off);
      sb.push_back(e);
    end
    @(negedge clkx5);
    resync = 1'b0;
    if (samp || data_valid) check_eq("data_valid", data_valid, samp);
    if (samp && sb.size() > 0) begin
      e = sb.pop_front();
      if (data_valid) begin
        check_eq("dataout", dataout, e.w);
        check_eq("token_det", token_det, e.det);
        check_eq("ctl", ctl, e.c);
        check_eq("locked", locked, e.lk);
        check_eq("bit_offset", bit_offset, e.off);
      end
    end
    if (data_valid) begin
      if (token_det) begin tok_cnt++; nontok_run = 0; end
      else nontok_run++;
      if (locked && !prev_lk && lock_tok < 0) lock_tok = tok_cnt;
      if (!locked && prev_lk) begin drop_run = nontok_run; drop_off = bit_offset; end
      if (bit_offset != prev_off) off_moves++;
      prev_lk = locked;
      prev_off = bit_offset;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; resync = 1'b0; din_h = 1'b0; din_l = 1'b0;
    repeat (2) @(posedge clkx5);
    @(negedge clkx5);
    check_eq("rst_dataout", dataout, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_token", token_det, 0);
    check_eq("rst_ctl", ctl, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_offset", bit_offset, 0);
    rst = 1'b0;
    n = 0;
    sent.delete(); sent.push_back(1'b0); sent.push_back(1'b0);
    sb.delete();
    m_state = 0; m_run = 0; m_miss = 0; m_idle = 0; m_off = 0;
    rs_on_lock = 1'b0;
    tok_cnt = 0; nontok_run = 0; lock_tok = -1; drop_run = -1; drop_off = -1;
    off_moves = 0; prev_off = 0; prev_lk = 1'b0;
  endtask

  initial begin
    int first;
    n_chk = 0; n_fail = 0;

    // Aligned 0x354 stream: lock on the 8th token word at offset 0.
    do_reset();
    cur_word = 10'h354; dly = 0;
    for (int i = 0; i < 60; i++) tick();
    check_eq("t1_lock_tokens", lock_tok, TR);
    check_eq("t1_locked", locked, 1);
    check_eq("t1_ctl", ctl, 2'b00);
    check_eq("t1_offset", bit_offset, 0);

    // 0x0AB delayed 3 bits: three slips, then lock at offset 3.
    do_reset();
    cur_word = 10'h0AB; dly = 3;
    for (int i = 0; i < 1500 && !locked; i++) tick();
    check_eq("t2_locked", locked, 1);
    check_eq("t2_offset", bit_offset, 3);
    check_eq("t2_dataout", dataout, 10'h0AB);
    check_eq("t2_ctl", ctl, 2'b01);
    check_eq("t2_slips", off_moves, 3);

    // Non-token data while locked: lock lost on the TW-th consecutive non-token word.
    cur_word = 10'h1F0;
    for (int i = 0; i < 21500 && locked; i++) tick();
    check_eq("t3_locked", locked, 0);
    check_eq("t3_idle_words", drop_run, TW);
    check_eq("t3_offset", drop_off, 4);

    // Resync on the very edge lock would assert.
    do_reset();
    cur_word = 10'h354; dly = 0;
    rs_on_lock = 1'b1;
    for (int i = 0; i < 500 && rs_on_lock; i++) tick();
    check_eq("t4_resync_hit", rs_on_lock, 0);
    check_eq("t4_locked", locked, 0);
    check_eq("t4_offset", bit_offset, 1);
    for (int i = 0; i < 100; i++) tick();
    check_eq("t4_slip_once", off_moves, 1);
    check_eq("t4_still_unlocked", locked, 0);

    // Asynchronous reset two cycles into a word.
    for (int i = 0; i < 10 && (n % 5) != 2; i++) tick();
    rst = 1'b1;
    #1;
    check_eq("t5_dataout", dataout, 0);
    check_eq("t5_valid", data_valid, 0);
    check_eq("t5_token", token_det, 0);
    check_eq("t5_ctl", ctl, 0);
    check_eq("t5_locked", locked, 0);
    check_eq("t5_offset", bit_offset, 0);
    @(posedge clkx5);
    @(negedge clkx5);
    rst = 1'b0;
    first = -1;
    for (int k = 1; k <= 8 && first < 0; k++) begin
      @(posedge clkx5);
      #1;
      if (data_valid) first = k;
    end
    check_eq("t5_first_valid_edge", first, 5);

    // 0x2AB stream (inverted on the wire when the polarity option is built in).
    do_reset();
    cur_word = 10'h2AB; dly = 0;
    for (int i = 0; i < 150 && !locked; i++) tick();
    check_eq("t6_locked", locked, 1);
    check_eq("t6_dataout", dataout, 10'h2AB);
    check_eq("t6_ctl", ctl, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tmds_deser_1to10.md
TMDS_DESER_1TO10 -- requirements
Module: tmds_deser_1to10

Interface
REQ-001 SHALL have parameter SEARCH_WORDS, default 64: consecutive non-token words tolerated at one offset in SEARCH before a bit slip.
REQ-002 SHALL have parameter TOKEN_RUN, default 8: consecutive control-token words required to declare lock.
REQ-003 SHALL have parameter TIMEOUT_WORDS, default 4096: consecutive non-token words tolerated in LOCKED before lock is lost.
REQ-004 SHALL have port clkx5  input  1: 5x pixel clock; the block's only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port din_h  input  1: earlier-in-time serial bit of the current DDR pair, captured externally.
REQ-007 SHALL have port din_l  input  1: later-in-time serial bit of the current DDR pair.
REQ-008 SHALL have port resync  input  1: one-cycle request to abandon the current alignment.
REQ-009 SHALL have port dataout  output  10: recovered TMDS word; bit 0 is the first bit received.
REQ-010 SHALL have port data_valid  output  1: one-cycle strobe qualifying dataout, ctl and token_det.
REQ-011 SHALL have port token_det  output  1: dataout is one of the four TMDS control tokens.
REQ-012 SHALL have port ctl  output  2: decoded control bits {C1,C0}; 0 when token_det=0.
REQ-013 SHALL have port locked  output  1: word alignment established.
REQ-014 SHALL have port bit_offset  output  4: current word-boundary offset, 0..9.

Function
REQ-015 SHALL shift each cycle a 20-bit history: hist <= {din_l, din_h, hist[19:2]}.
REQ-016 SHALL run a mod-5 phase counter 0..4, wrapping 4->0.
REQ-017 SHALL, on each cycle with phase=4, register dataout = hist[bit_offset+9 : bit_offset] and pulse data_valid for exactly one cycle (one word per 5 cycles, word valid 1 cycle after sampling).
REQ-018 SHALL decode tokens: 10'h354->ctl 00, 10'h0AB->01, 10'h154->10, 10'h2AB->11; token_det and ctl registered alongside dataout.
REQ-019 SHALL implement states SEARCH and LOCKED, with run counter, miss counter and idle counter evaluated only on word-sample cycles.
REQ-020 SHALL in SEARCH: token word -> run+1, miss=0; non-token -> run=0, miss+1.
REQ-021 SHALL in SEARCH, when run reaches TOKEN_RUN, enter LOCKED, assert locked the following cycle, clear idle.
REQ-022 SHALL in SEARCH, when miss reaches SEARCH_WORDS, slip: bit_offset+1 (9 wraps to 0), clear run and miss.
REQ-023 SHALL in LOCKED: token -> idle=0; non-token -> idle+1; idle reaching TIMEOUT_WORDS -> SEARCH, slip, locked=0.
REQ-024 SHALL on resync=1 in any state: enter SEARCH, slip, clear all counters, deassert locked; resync takes priority over a same-cycle lock or timeout transition (single slip only).
REQ-025 SHALL keep data_valid pulsing every 5 cycles regardless of state; phase counter never reset by slips.
REQ-026 SHALL saturate all counters at their terminal values; no wrap to zero without a transition.

Reset
REQ-027 SHALL, while rst=1, hold: hist=0, phase=0, state=SEARCH, counters=0, bit_offset=0, dataout=0, data_valid=0, token_det=0, ctl=0, locked=0.
REQ-028 SHALL, on rst assertion mid-word or mid-lock, abandon the partial word immediately; first data_valid after release occurs on the 5th rising edge.

Configuration
REQ-029 SHALL honour macro TMDS_DESER_POLINV_EN: defined -> din_h and din_l inverted before entering hist (swapped P/N routing); undefined -> used as-is, no inversion logic.

Verification
REQ-030 SHALL verify: stream 10'h354 repeated at offset 0 after reset -> locked=1 after 8th token word, ctl=00, bit_offset=0.
REQ-031 SHALL verify: 10'h0AB stream delayed 3 bits -> slips every 64 non-token words, locks at bit_offset=3 with dataout=10'h0AB, ctl=01.
REQ-032 SHALL verify: locked, then 4096 consecutive 10'h1F0 words -> locked drops on the 4096th, bit_offset increments by 1.
REQ-033 SHALL verify: resync pulse on the same cycle lock would assert -> locked stays 0, bit_offset increments exactly once.
REQ-034 SHALL verify: rst asserted 2 cycles into a word -> all outputs 0 immediately; first data_valid on 5th edge after release.
REQ-035 SHALL verify: with TMDS_DESER_POLINV_EN, inverted 10'h2AB stream -> locks with dataout=10'h2AB, ctl=11.
